// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: per-bit synchroniser, debounce counter and edge pulses.
// Optional sticky edge capture with irq is built when SW_EDGE_CAPTURE_EN is defined.
module sw_debounce_sync #(
   parameter int WIDTH           = 10,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed,
   input  logic [WIDTH-1:0] capture_clr,
   output logic [WIDTH-1:0] edge_capture,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync_lvl;
   logic [CNT_W-1:0] cnt_q  [WIDTH];

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= sw_raw;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   // Any agreement with the accepted level restarts the count, so glitches never accumulate.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         sw_out  <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            sw_rise[i] <= 1'b0;
            sw_fall[i] <= 1'b0;
            if (sync_lvl[i] == sw_out[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               sw_out[i]  <= sync_lvl[i];
               sw_rise[i] <= sync_lvl[i];
               sw_fall[i] <= ~sync_lvl[i];
               cnt_q[i]   <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign sw_changed = |(sw_rise | sw_fall);

`ifdef SW_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] cap_nxt;

   // Set has priority over clear so an event arriving with a clear is kept.
   always_comb begin
      cap_nxt = (edge_capture & ~capture_clr) | sw_rise | sw_fall;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
         irq          <= 1'b0;
      end else begin
         edge_capture <= cap_nxt;
         irq          <= |cap_nxt;
      end
   end
`else
   logic unused_capture_clr;

   assign unused_capture_clr = ^capture_clr;
   assign edge_capture       = '0;
   assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_sw_debounce_sync;

   localparam int W = 10;
`ifdef SW_EDGE_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic         clk;
   logic         reset_n;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_out;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         sw_changed;
   logic [W-1:0] capture_clr;
   logic [W-1:0] edge_capture;
   logic         irq;

   int vectors;
   int miscompares;

   sw_debounce_sync #(
      .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(3)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .sw_out(sw_out),
      .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed),
      .capture_clr(capture_clr), .edge_capture(edge_capture), .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for sw_out to reach target; n is ticks taken (20 on timeout).
   task automatic wait_out(input logic [W-1:0] target, output int n);
      n = 0;
      while (sw_out !== target && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic clear_capture();
      capture_clr = '1;
      tick();
      capture_clr = '0;
   endtask

   initial begin
      int n;
      int rises;
      int falls;
      int seen;
      int first_rise;
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      sw_raw      = 10'h3FF;
      capture_clr = '0;

      // Reset with all switches high
      repeat (3) tick();
      chk("rst_out", 32'(sw_out), 32'h0);
      chk("rst_rise", 32'(sw_rise), 32'h0);
      chk("rst_fall", 32'(sw_fall), 32'h0);
      chk("rst_changed", 32'(sw_changed), 32'h0);
      chk("rst_capture", 32'(edge_capture), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_out(10'h3FF, n);
      chk("rel_latency_ok", 32'(n >= 5 && n <= 7), 32'h1);
      chk("rel_rise", 32'(sw_rise), 32'h3FF);
      chk("rel_fall", 32'(sw_fall), 32'h0);
      chk("rel_changed", 32'(sw_changed), 32'h1);
      tick();
      chk("rel_rise_1cyc", 32'(sw_rise), 32'h0);
      chk("rel_changed_1cyc", 32'(sw_changed), 32'h0);
      chk("rel_out_hold", 32'(sw_out), 32'h3FF);
      chk("rel_capture", 32'(edge_capture), CAP ? 32'h3FF : 32'h0);
      clear_capture();
      tick();
      chk("clrall_capture", 32'(edge_capture), 32'h0);

      // All switches back low
      sw_raw = 10'h000;
      wait_out(10'h000, n);
      chk("all_fall_latency_ok", 32'(n >= 5 && n <= 7), 32'h1);
      chk("all_fall_pulse", 32'(sw_fall), 32'h3FF);
      chk("all_fall_norise", 32'(sw_rise), 32'h0);
      tick();
      clear_capture();

      // Clean edge on bit 3
      sw_raw = 10'h008;
      wait_out(10'h008, n);
      chk("b3_latency_ok", 32'(n >= 5 && n <= 7), 32'h1);
      chk("b3_out", 32'(sw_out), 32'h008);
      chk("b3_rise", 32'(sw_rise), 32'h008);
      tick();
      chk("b3_rise_1cyc", 32'(sw_rise), 32'h0);

      // Glitch of 3 cycles on bit 0 is rejected
      seen = 0;
      sw_raw = 10'h009;
      repeat (3) begin tick(); seen += int'(sw_out[0] | sw_rise[0]); end
      sw_raw = 10'h008;
      repeat (12) begin tick(); seen += int'(sw_out[0] | sw_rise[0]); end
      chk("glitch3_reject", 32'(seen), 32'h0);
      chk("glitch3_out", 32'(sw_out), 32'h008);

      // A 5-cycle high on bit 0 is accepted, then the return low is accepted too
      rises = 0;
      falls = 0;
      sw_raw = 10'h009;
      repeat (5) begin tick(); rises += int'(sw_rise[0]); falls += int'(sw_fall[0]); end
      sw_raw = 10'h008;
      repeat (12) begin tick(); rises += int'(sw_rise[0]); falls += int'(sw_fall[0]); end
      chk("pulse5_rises", 32'(rises), 32'h1);
      chk("pulse5_falls", 32'(falls), 32'h1);
      chk("pulse5_out", 32'(sw_out), 32'h008);

      // Bounce on bit 9: 2-cycle toggles, then a steady high
      rises = 0;
      for (int i = 0; i < 10; i++) begin
         sw_raw[9] = (i % 2 == 0);
         repeat (2) begin tick(); rises += int'(sw_rise[9]); end
      end
      chk("bounce_no_rise", 32'(rises), 32'h0);
      sw_raw[9] = 1'b1;
      first_rise = -1;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (sw_rise[9]) begin
            rises++;
            if (first_rise < 0) first_rise = t;
         end
      end
      chk("bounce_one_rise", 32'(rises), 32'h1);
      chk("bounce_rise_time_ok", 32'(first_rise >= 5 && first_rise <= 7), 32'h1);
      chk("bounce_out", 32'(sw_out), 32'h208);
      clear_capture();

      // Reset two cycles into a pending rise on bit 5
      sw_raw = 10'h228;
      repeat (2) tick();
      reset_n = 1'b0;
      #1;
      chk("midrst_out", 32'(sw_out), 32'h0);
      chk("midrst_rise", 32'(sw_rise), 32'h0);
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      wait_out(10'h228, n);
      chk("midrst_latency_ok", 32'(n >= 5 && n <= 7), 32'h1);
      chk("midrst_rise_all", 32'(sw_rise), 32'h228);
      tick();
      clear_capture();
      tick();
      chk("pre_b2_capture", 32'(edge_capture), 32'h0);

      // Edge capture on bit 2
      sw_raw = 10'h22C;
      wait_out(10'h22C, n);
      chk("b2_rise", 32'(sw_rise), 32'h004);
      tick();
      chk("b2_capture", 32'(edge_capture), CAP ? 32'h004 : 32'h0);
      chk("b2_irq", 32'(irq), CAP ? 32'h1 : 32'h0);
      capture_clr = 10'h004;
      tick();
      capture_clr = '0;
      chk("b2_clr_capture", 32'(edge_capture), 32'h0);
      chk("b2_clr_irq", 32'(irq), 32'h0);

      // Clear coincident with a new bit-2 event: the event wins
      sw_raw = 10'h228;
      wait_out(10'h228, n);
      chk("b2_fall", 32'(sw_fall), 32'h004);
      capture_clr = 10'h004;
      tick();
      capture_clr = '0;
      chk("b2_setwins_capture", 32'(edge_capture), CAP ? 32'h004 : 32'h0);
      chk("b2_setwins_irq", 32'(irq), CAP ? 32'h1 : 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
